// File: rtl/bist_pkg.sv
// Shared types and build defaults for the CLA BIST response-evaluation stage.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int             SIG_W       = 4;
    localparam logic [SIG_W-1:0] GOLDEN_SIG  = 4'h0;
    localparam int             TIMEOUT_CYC = 16;

endpackage

// File: rtl/bist_sig_checker.sv
// Runs one SISR session, captures its signature on completion and grades it
// against the golden value, with a timeout so a stuck SISR reports a failure.
module bist_sig_checker #(
    parameter int                SIG_W       = bist_pkg::SIG_W,
    parameter logic [SIG_W-1:0]  GOLDEN_SIG  = bist_pkg::GOLDEN_SIG,
    parameter int                TIMEOUT_CYC = bist_pkg::TIMEOUT_CYC,
    parameter int                CNT_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             enc,
    input  logic [SIG_W-1:0] sig,
    output logic             ens,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [SIG_W-1:0] captured_sig,
    output logic [CNT_W-1:0] run_cycles
);
    import bist_pkg::*;

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             timeout_q, timeout_d;
    logic [SIG_W-1:0] cap_q, cap_d;
    logic [CNT_W-1:0] run_cycles_q, run_cycles_d;

    // Saturate so the counter can never wrap even if TIMEOUT_CYC is near 2^CNT_W.
    assign cnt_inc = (cnt_q == TO_VAL) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        timeout_d    = timeout_q;
        cap_d        = cap_q;
        run_cycles_d = run_cycles_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = RUN;
                    cnt_d        = '0;
                    pass_d       = 1'b0;
                    fail_d       = 1'b0;
                    timeout_d    = 1'b0;
                    cap_d        = '0;
                    run_cycles_d = '0;
                end else if (abort && state_q == DONE) begin
                    state_d      = IDLE;
                    pass_d       = 1'b0;
                    fail_d       = 1'b0;
                    timeout_d    = 1'b0;
                    cap_d        = '0;
                    run_cycles_d = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (abort) begin
                    state_d = IDLE;
                end else if (enc) begin
                    // SISR clears once ens drops, so the signature must be taken now.
                    state_d      = CHECK;
                    cap_d        = sig;
                    run_cycles_d = cnt_inc;
                end else if (cnt_inc == TO_VAL) begin
                    state_d      = DONE;
                    pass_d       = 1'b0;
                    fail_d       = 1'b1;
                    timeout_d    = 1'b1;
                    cap_d        = sig;
                    run_cycles_d = TO_VAL;
                end
            end
            CHECK: begin
                state_d   = DONE;
                pass_d    = (cap_q == GOLDEN_SIG);
                fail_d    = (cap_q != GOLDEN_SIG);
                timeout_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
            cap_q        <= '0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
            cap_q        <= cap_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    assign ens          = (state_q == RUN);
    assign busy         = (state_q == RUN) || (state_q == CHECK);
    assign done         = (state_q == DONE);
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign timeout      = timeout_q;
    assign captured_sig = cap_q;
    assign run_cycles   = run_cycles_q;

endmodule

// File: tb/tb_bist_sig_checker.sv
// Directed bench for bist_sig_checker: golden match, mismatch, timeout, abort, restart.
module tb_bist_sig_checker;

    localparam int SIG_W = 4;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst, start, abort, enc;
    logic [SIG_W-1:0] sig;
    logic             ens, busy, done, pass, fail, timeout;
    logic [SIG_W-1:0] captured_sig;
    logic [CNT_W-1:0] run_cycles;

    int n_cmp = 0;
    int n_err = 0;

    bist_sig_checker #(
        .SIG_W(SIG_W), .GOLDEN_SIG(4'hB), .TIMEOUT_CYC(16), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .enc(enc), .sig(sig),
        .ens(ens), .busy(busy), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .captured_sig(captured_sig), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {ens,busy,done,pass,fail,timeout}
    function automatic logic [5:0] flags();
        return {ens, busy, done, pass, fail, timeout};
    endfunction

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; enc = 1'b0; sig = '0;
        step(); step();
        rst = 1'b0;
        step();
        chk("reset_flags", 32'(flags()), 32'b000000);
        chk("reset_cap", 32'(captured_sig), 32'h0);
        chk("reset_runc", 32'(run_cycles), 32'h0);

        // reset mid-RUN
        start = 1'b1; step(); start = 1'b0;
        chk("run_ens", 32'(flags()), 32'b110000);
        step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_midrun", 32'(flags()), 32'b000000);
        rst = 1'b1; start = 1'b1; step(); rst = 1'b0; start = 1'b0;
        chk("rst_start", 32'(flags()), 32'b000000);
        step();
        chk("rst_start_idle", 32'(flags()), 32'b000000);

        // golden match, enc on RUN cycle 8
        start = 1'b1; step(); start = 1'b0;
        run_idle(7);
        chk("gold_run7", 32'(flags()), 32'b110000);
        enc = 1'b1; sig = 4'hB; step(); enc = 1'b0; sig = 4'h0;
        chk("gold_check", 32'(flags()), 32'b010000);
        chk("gold_cap", 32'(captured_sig), 32'hB);
        chk("gold_runc", 32'(run_cycles), 32'd8);
        step();
        chk("gold_done", 32'(flags()), 32'b001100);
        chk("gold_cap_hold", 32'(captured_sig), 32'hB);

        // mismatch, restarted from DONE
        start = 1'b1; step(); start = 1'b0;
        chk("mis_clear", 32'(flags()), 32'b110000);
        chk("mis_clear_cap", 32'(captured_sig), 32'h0);
        run_idle(7);
        enc = 1'b1; sig = 4'h3; step(); enc = 1'b0; sig = 4'h0;
        step();
        chk("mis_done", 32'(flags()), 32'b001010);
        chk("mis_cap", 32'(captured_sig), 32'h3);
        chk("mis_runc", 32'(run_cycles), 32'd8);

        // timeout with enc held low
        start = 1'b1; step(); start = 1'b0;
        sig = 4'h5;
        run_idle(15);
        chk("to_run15", 32'(flags()), 32'b110000);
        step();
        sig = 4'h0;
        chk("to_done", 32'(flags()), 32'b001011);
        chk("to_runc", 32'(run_cycles), 32'd16);
        chk("to_cap", 32'(captured_sig), 32'h5);

        // enc on the exact timeout cycle wins
        start = 1'b1; step(); start = 1'b0;
        run_idle(15);
        enc = 1'b1; sig = 4'hB; step(); enc = 1'b0; sig = 4'h0;
        chk("edge_check", 32'(flags()), 32'b010000);
        chk("edge_runc", 32'(run_cycles), 32'd16);
        step();
        chk("edge_done", 32'(flags()), 32'b001100);

        // abort with enc on RUN cycle 5
        start = 1'b1; step(); start = 1'b0;
        run_idle(4);
        abort = 1'b1; enc = 1'b1; sig = 4'hB; step();
        abort = 1'b0; enc = 1'b0; sig = 4'h0;
        chk("abort_flags", 32'(flags()), 32'b000000);
        chk("abort_cap", 32'(captured_sig), 32'h0);
        chk("abort_runc", 32'(run_cycles), 32'h0);
        step();
        chk("abort_idle", 32'(flags()), 32'b000000);

        // full session after abort, start ignored while running
        start = 1'b1; step();
        run_idle(2);
        start = 1'b0;
        enc = 1'b1; sig = 4'h3; step(); enc = 1'b0; sig = 4'h0;
        chk("post_abort_runc", 32'(run_cycles), 32'd3);
        step();
        chk("post_abort_done", 32'(flags()), 32'b001010);

        // restart from DONE with start and abort together
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        chk("restart_flags", 32'(flags()), 32'b110000);
        chk("restart_cap", 32'(captured_sig), 32'h0);
        chk("restart_runc", 32'(run_cycles), 32'h0);

        // abort from DONE clears results
        enc = 1'b1; sig = 4'hB; step(); enc = 1'b0; sig = 4'h0;
        chk("fast_runc", 32'(run_cycles), 32'd1);
        step();
        chk("fast_done", 32'(flags()), 32'b001100);
        abort = 1'b1; step(); abort = 1'b0;
        chk("done_abort", 32'(flags()), 32'b000000);
        chk("done_abort_cap", 32'(captured_sig), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
